// File: rtl/audio_sample_buffer.sv
// -----------------------------------------------------------------------------
// audio_sample_buffer
//
// Decimates the continuously updated 16-bit stereo core audio words to a fixed
// sample rate and queues each stereo pair in a small FWFT FIFO. The I2S
// serializer pulls frames with a valid/ready handshake, so left/right words
// always leave together.
//
// Configuration macro: AUDIO_BUF_AVG_EN
//   defined   -> boxcar average of 2^AVG_LOG2 subsamples per frame (floor)
//   undefined -> pure decimation: the sample from the last tick of each group
//
// Parameters:
//   DIV        clocks per subsample tick (>= 2)
//   AVG_LOG2   log2 of subsamples per output frame (0..4)
//   DEPTH_LOG2 log2 of FIFO depth in stereo frames (>= 1)
//
// Ports:
//   clk         system clock, the only clock
//   reset_n     asynchronous active-low reset
//   audio_l_in  signed left sample from the core
//   audio_r_in  signed right sample from the core
//   mute        forces pushed frames to zero
//   clr_flags   synchronous clear of the sticky flags (a set wins)
//   o_valid     head frame available
//   o_ready     consumer accepts the head frame this cycle
//   o_left      head frame, left word
//   o_right     head frame, right word
//   level       FIFO occupancy in frames
//   overflow    sticky: a frame was dropped on a full FIFO
//   underflow   sticky: o_ready seen while o_valid was low
// -----------------------------------------------------------------------------
module audio_sample_buffer #(
  parameter int DIV        = 16,
  parameter int AVG_LOG2   = 2,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           audio_l_in,
  input  logic [15:0]           audio_r_in,
  input  logic                  mute,
  input  logic                  clr_flags,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [15:0]           o_left,
  output logic [15:0]           o_right,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DIV_W = $clog2(DIV);
  localparam int SUB_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'((1 << AVG_LOG2) - 1);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Subsample timing: a tick every DIV clocks, a push on the last tick of each
  // group of 2^AVG_LOG2 ticks.
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_q;
  logic [SUB_W-1:0] sub_cnt_q;
  logic             tick;
  logic             sub_last;
  logic             push;

  assign tick     = (div_cnt_q == DIV_LAST);
  assign sub_last = (sub_cnt_q == SUB_LAST);
  assign push     = tick & sub_last;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge value of every register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt_q <= '0;
      sub_cnt_q <= '0;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
      if (tick) begin
        sub_cnt_q <= sub_last ? '0 : sub_cnt_q + SUB_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame value
  // ---------------------------------------------------------------------------
  logic [15:0] frame_l;
  logic [15:0] frame_r;

`ifdef AUDIO_BUF_AVG_EN
  // 16+AVG_LOG2 bits hold the sum of 2^AVG_LOG2 signed 16-bit samples exactly.
  localparam int ACC_W = 16 + AVG_LOG2;

  logic signed [ACC_W-1:0] acc_l_q;
  logic signed [ACC_W-1:0] acc_r_q;
  logic signed [ACC_W-1:0] ext_l;
  logic signed [ACC_W-1:0] ext_r;
  logic signed [ACC_W-1:0] sum_l;
  logic signed [ACC_W-1:0] sum_r;

  assign ext_l = ACC_W'($signed(audio_l_in));
  assign ext_r = ACC_W'($signed(audio_r_in));
  assign sum_l = acc_l_q + ext_l;
  assign sum_r = acc_r_q + ext_r;

  // Arithmetic shift floors toward minus infinity (-1.25 -> -2).
  assign frame_l = 16'(sum_l >>> AVG_LOG2);
  assign frame_r = 16'(sum_r >>> AVG_LOG2);

  // The accumulators keep running while muted so unmuting mid-group still
  // yields the true average of the whole group.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
    end else if (tick) begin
      acc_l_q <= sub_last ? '0 : sum_l;
      acc_r_q <= sub_last ? '0 : sum_r;
    end
  end
`else
  assign frame_l = audio_l_in;
  assign frame_r = audio_r_in;
`endif

  // ---------------------------------------------------------------------------
  // FIFO: circular buffer, first-word-fall-through head at rd_ptr_q
  // ---------------------------------------------------------------------------
  logic [31:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic [DEPTH_LOG2:0]   count_d;
  logic [31:0]           wr_data;
  logic                  full;
  logic                  pop;
  logic                  wr_en;
  logic                  ovf_set;
  logic                  unf_set;

  assign full    = (count_q == FULL_CNT);
  assign o_valid = (count_q != '0);
  assign pop     = o_valid & o_ready;
  // A full FIFO still accepts the frame when the head leaves in the same cycle.
  assign wr_en   = push & (~full | pop);
  assign ovf_set = push & full & ~pop;
  assign unf_set = o_ready & ~o_valid;
  assign wr_data = mute ? 32'h0000_0000 : {frame_l, frame_r};

  // NOTE: count_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage is reset as well; it is only a few frames deep, and it
  // guarantees the head words read zero out of reset and after a mid-stream
  // reset rather than showing stale audio.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + DEPTH_LOG2'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      end
      count_q <= count_d;
    end
  end

  assign o_left  = mem_q[rd_ptr_q][31:16];
  assign o_right = mem_q[rd_ptr_q][15:0];
  assign level   = count_q;

  // ---------------------------------------------------------------------------
  // Sticky flags: a set condition overrides a simultaneous clear.
  // ---------------------------------------------------------------------------
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_set)        overflow_q <= 1'b1;
      else if (clr_flags) overflow_q <= 1'b0;
      if (unf_set)        underflow_q <= 1'b1;
      else if (clr_flags) underflow_q <= 1'b0;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_audio_sample_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for audio_sample_buffer (DIV=4, AVG_LOG2=2, DEPTH_LOG2=3).
// Reference model: cycle count since reset, a list of the subsamples taken in
// the current group, and a queue of frames standing for the FIFO. Averages are
// computed with integer floor division.
// -----------------------------------------------------------------------------
module tb_audio_sample_buffer;

  localparam int DIV        = 4;
  localparam int AVG_LOG2   = 2;
  localparam int DEPTH_LOG2 = 3;
  localparam int N          = 1 << AVG_LOG2;
  localparam int P          = DIV * N;
  localparam int CAP        = 1 << DEPTH_LOG2;

`ifdef AUDIO_BUF_AVG_EN
  localparam bit AVG_EN = 1'b1;
`else
  localparam bit AVG_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset_n;
  logic [15:0]         audio_l_in;
  logic [15:0]         audio_r_in;
  logic                mute;
  logic                clr_flags;
  logic                o_valid;
  logic                o_ready;
  logic [15:0]         o_left;
  logic [15:0]         o_right;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic                underflow;

  audio_sample_buffer #(
    .DIV        (DIV),
    .AVG_LOG2   (AVG_LOG2),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .audio_l_in (audio_l_in),
    .audio_r_in (audio_r_in),
    .mute       (mute),
    .clr_flags  (clr_flags),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_left     (o_left),
    .o_right    (o_right),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          m_cyc;
  int          grp_l[$];
  int          grp_r[$];
  logic [31:0] fq[$];
  bit          m_ovf;
  bit          m_unf;

  function automatic int floor_div(input int s, input int d);
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  function automatic int group_value(input int g[$]);
    int s = 0;
    if (!AVG_EN) return g[g.size() - 1];
    foreach (g[i]) s += g[i];
    return floor_div(s, g.size());
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    grp_l.delete();
    grp_r.delete();
    fq.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Advances the model over the clock edge that ends cycle m_cyc, using the
  // inputs currently driven.
  task automatic model_step();
    bit          pop_now;
    bit          push_now;
    bit          ovf_now;
    bit          unf_now;
    int          vl;
    int          vr;
    logic [31:0] fr;
    pop_now  = o_ready && (fq.size() != 0);
    unf_now  = o_ready && (fq.size() == 0);
    push_now = 1'b0;
    fr       = '0;
    if (m_cyc % DIV == DIV - 1) begin
      grp_l.push_back(int'($signed(audio_l_in)));
      grp_r.push_back(int'($signed(audio_r_in)));
      if (grp_l.size() == N) begin
        push_now = 1'b1;
        vl = group_value(grp_l);
        vr = group_value(grp_r);
        fr = mute ? 32'h0 : {16'(vl), 16'(vr)};
        grp_l.delete();
        grp_r.delete();
      end
    end
    ovf_now = push_now && (fq.size() == CAP) && !pop_now;
    if (pop_now) void'(fq.pop_front());
    if (push_now && !ovf_now) fq.push_back(fr);
    m_ovf = ovf_now ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
    m_unf = unf_now ? 1'b1 : (clr_flags ? 1'b0 : m_unf);
    m_cyc++;
  endtask

  task automatic check_outputs();
    check("o_valid", o_valid, fq.size() != 0);
    check("level", level, fq.size());
    if (fq.size() != 0) begin
      check("o_left", o_left, fq[0][31:16]);
      check("o_right", o_right, fq[0][15:0]);
    end
    check("overflow", overflow, m_ovf);
    check("underflow", underflow, m_unf);
  endtask

  function automatic bit is_push_cycle();
    return (m_cyc % P) == P - 1;
  endfunction

  // Drives one cycle of inputs, steps the model, and checks #1 after the edge.
  task automatic run_cycle(input logic [15:0] l, input logic [15:0] r,
                           input logic m, input logic clr, input logic rdy);
    audio_l_in = l;
    audio_r_in = r;
    mute       = m;
    clr_flags  = clr;
    o_ready    = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * P && fq.size() != 0; i++) begin
      run_cycle(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    end
    check("drain_empty", o_valid, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          pulses;
    int          seen;
    bit          found;
    logic [15:0] floor_exp;
    int          floor_seq[4];

    reset_n    = 1'b0;
    audio_l_in = '0;
    audio_r_in = '0;
    mute       = 1'b0;
    clr_flags  = 1'b0;
    o_ready    = 1'b0;
    model_reset();

    #22;
    check("rst_valid", o_valid, 1'b0);
    check("rst_level", level, 0);
    check("rst_left", o_left, 16'h0000);
    check("rst_right", o_right, 16'h0000);
    check("rst_ovf", overflow, 1'b0);
    check("rst_unf", underflow, 1'b0);
    reset_n = 1'b1;

    // Constant input with the consumer always ready.
    pulses = 0;
    for (int i = 0; i < 4 * P; i++) begin
      run_cycle(16'h1000, 16'hF000, 1'b0, 1'b0, 1'b1);
      if (o_valid) begin
        pulses++;
        check("avg_left", o_left, 16'h1000);
        check("avg_right", o_right, 16'hF000);
      end
    end
    check("avg_pulses", pulses, 4);
    check("avg_unf", underflow, 1'b1);

    // Floor rounding: subsamples -2, -1, -1, -1 in each group.
    floor_seq = '{-2, -1, -1, -1};
    floor_exp = AVG_EN ? 16'hFFFE : 16'hFFFF;
    seen = 0;
    for (int i = 0; i < 2 * P; i++) begin
      run_cycle(16'(floor_seq[(m_cyc % P) / DIV]), 16'h0003, 1'b0, 1'b0, 1'b1);
      if (o_valid) begin
        seen++;
        check("floor_left", o_left, floor_exp);
      end
    end
    check("floor_frames", seen, 2);

    // Overflow: no consumer for ten pushes.
    drain();
    for (int i = 0; i < (CAP + 2) * P; i++) begin
      run_cycle(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    end
    check("ovf_level", level, CAP);
    check("ovf_flag", overflow, 1'b1);
    if (is_push_cycle()) run_cycle(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0);
    run_cycle(16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0);
    check("ovf_clr", overflow, 1'b0);

    // Full FIFO, consumer ready only in push cycles.
    for (int i = 0; i < 3 * P; i++) begin
      found = is_push_cycle();
      run_cycle(16'($urandom), 16'($urandom), 1'b0, 1'b0, found);
      if (found) begin
        check("fullpop_level", level, CAP);
        check("fullpop_ovf", overflow, 1'b0);
      end
    end
    drain();

    // Mute for a while, then unmute mid-group.
    for (int i = 0; i < 3 * P; i++) begin
      run_cycle(16'($urandom) | 16'h0100, 16'($urandom) | 16'h0100, 1'b1, 1'b0, 1'b1);
      if (o_valid) begin
        check("mute_left", o_left, 16'h0000);
        check("mute_right", o_right, 16'h0000);
      end
    end
    while ((m_cyc % P) != P / 2) begin
      run_cycle(16'($urandom), 16'($urandom), 1'b1, 1'b0, 1'b1);
    end
    for (int i = 0; i < 2 * P; i++) begin
      run_cycle(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    end

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] l;
      logic [15:0] r;
      if ($urandom_range(0, 1) == 0) begin
        l = 16'($urandom);
        r = 16'($urandom);
      end else begin
        l = 16'($signed($urandom_range(0, 6)) - 3);
        r = 16'($signed($urandom_range(0, 6)) - 3);
      end
      run_cycle(l, r, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 2) == 0);
    end

    // Reset mid-operation with five frames queued and sub_cnt at 2.
    drain();
    found = 1'b0;
    for (int i = 0; i < 8 * P && !found; i++) begin
      run_cycle(16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
      found = (fq.size() == 5) && ((m_cyc % P) / DIV == 2);
    end
    check("rst_mid_setup", found, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_valid", o_valid, 1'b0);
    check("rstmid_level", level, 0);
    check("rstmid_left", o_left, 16'h0000);
    check("rstmid_right", o_right, 16'h0000);
    check("rstmid_ovf", overflow, 1'b0);
    check("rstmid_unf", underflow, 1'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < P; i++) begin
      run_cycle(16'h2222, 16'hDDDD, 1'b0, 1'b0, 1'b0);
      if (i == P - 2) check("rstmid_nopush", level, 0);
      if (i == P - 1) check("rstmid_push", level, 1);
    end
    check("rstmid_head", o_left, 16'h2222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
